prbs7_checker: RTL

PRBS7_CHECKER -- requirements
Module: prbs7_checker

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/sat_counter.sv | 42 ++++
 rtl/prbs7_checker.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// ---------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the PRBS7 checker: FSM state type, sequence length,
// LFSR tap positions within the history register, and error-window length.
// No ports (package).
// ---------------------------------------------------------------------------
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned TAP_NEW    = 0;   // h[0], most recent bit
    localparam int unsigned TAP_OLD    = 6;   // h[6], oldest bit
    localparam int unsigned WINDOW_LEN = 32;

    // Next bit predicted by x^7+x^6+1: s[n] = s[n-1] ^ s[n-7].
    function automatic logic prbs7_expect(input logic [PRBS7_LEN-1:0] h);
        return h[TAP_NEW] ^ h[TAP_OLD];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear; clear has priority over
// increment. Holds at all-ones once reached.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   clr_i    : synchronous clear
//   inc_i    : increment request
//   count_o  : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/prbs7_checker.sv
// ---------------------------------------------------------------------------
// prbs7_checker
// Self-synchronising PRBS7 (x^7+x^6+1) stream checker. Every valid bit is
// shifted into a 7-bit history; the next bit is predicted from that history.
// SEARCH fills the history, VERIFY requires LOCK_CNT consecutive matches,
// LOCKED reports errors and drops lock after UNLOCK_ERRS errors inside one
// 32-bit window.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : in_bit valid this cycle (all state holds when low)
//   in_bit     : serial PRBS7 bit
//   clr_cnt    : synchronous clear of err_count (and bit_count)
//   locked     : checker synchronised (registered)
//   err_pulse  : one-cycle flag, mismatch seen while locked
//   err_count  : saturating error count while locked
//   bit_count  : valid bits received while locked (only with
//                PRBS_CHK_BITCNT_EN defined)
// Optional feature macro: PRBS_CHK_BITCNT_EN
// ---------------------------------------------------------------------------
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned UNLOCK_ERRS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_count
`endif
);

    localparam int unsigned FILL_W  = $clog2(PRBS7_LEN + 1);
    localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W   = $clog2(WINDOW_LEN);
    localparam int unsigned TALLY_W = $clog2(UNLOCK_ERRS + 1);

    state_e               state_q, state_d;
    logic [PRBS7_LEN-1:0] h_q, h_d;
    logic [FILL_W-1:0]    fill_q, fill_d, fill_inc;
    logic [GOOD_W-1:0]    good_q, good_d, good_inc;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [TALLY_W-1:0]   tally_q, tally_d, tally_inc;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 mismatch;
    logic                 err_inc;

    assign mismatch = in_bit ^ prbs7_expect(h_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SEARCH;
            h_q         <= '0;
            fill_q      <= '0;
            good_q      <= '0;
            win_q       <= '0;
            tally_q     <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            fill_q      <= fill_d;
            good_q      <= good_d;
            win_q       <= win_d;
            tally_q     <= tally_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        h_d       = h_q;
        fill_d    = fill_q;
        good_d    = good_q;
        win_d     = win_q;
        tally_d   = tally_q;
        // Fill saturates at 7 so an all-zero history keeps being re-tested
        // on each new bit until a non-zero history appears.
        fill_inc  = (fill_q == FILL_W'(PRBS7_LEN)) ? fill_q : fill_q + 1'b1;
        good_inc  = good_q + 1'b1;
        tally_inc = tally_q + TALLY_W'(mismatch);

        if (in_valid) begin
            h_d = {h_q[PRBS7_LEN-2:0], in_bit};
            case (state_q)
                ST_SEARCH: begin
                    fill_d = fill_inc;
                    if ((fill_inc == FILL_W'(PRBS7_LEN)) && (h_d != '0)) begin
                        state_d = ST_VERIFY;
                        good_d  = '0;
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                    end else begin
                        good_d = good_inc;
                        if (good_inc == GOOD_W'(LOCK_CNT)) begin
                            state_d = ST_LOCKED;
                            win_d   = '0;
                            tally_d = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // The current bit's error is added before the window
                    // wrap is considered, so a last-bit error still counts.
                    if (tally_inc >= TALLY_W'(UNLOCK_ERRS)) begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                        good_d  = '0;
                        win_d   = '0;
                        tally_d = '0;
                    end else if (win_q == WIN_W'(WINDOW_LEN - 1)) begin
                        win_d   = '0;
                        tally_d = '0;
                    end else begin
                        win_d   = win_q + 1'b1;
                        tally_d = tally_inc;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        err_inc     = in_valid && (state_q == ST_LOCKED) && mismatch;
        err_pulse_d = err_inc;
        locked_d    = (state_d == ST_LOCKED);
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk_i   (clk),
        .rst_ni  (rst),
        .clr_i   (clr_cnt),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count_q, bit_count_d;

    always_comb begin
        bit_count_d = bit_count_q;
        if (clr_cnt) begin
            bit_count_d = '0;
        end else if (in_valid && (state_q == ST_LOCKED)) begin
            bit_count_d = bit_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count_q <= '0;
        end else begin
            bit_count_q <= bit_count_d;
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule
